// File: rtl/tone_sequencer.sv
// tone_sequencer: note-sequencing controller for the 11-bit tone generator divider.
//
// Host note entries {divider, duration} are buffered in a DEPTH-entry FIFO. Each
// divider is written into the generator's three nibble registers over the shared
// 4-bit bus (LSEL -> HSEL -> HHSEL), then the note is held for NOTE_DUR TICKs.
// A divider of 0 is a rest: no bus writes, MUTE stays high for the duration.
//
// Ports:
//   CLK         system clock, rising edge
//   RST_C       asynchronous active-low reset
//   TICK        duration timebase strobe (one CLK wide)
//   ENABLE      playback enable
//   NOTE_DIV    divider of the pushed note (0 = rest)
//   NOTE_DUR    note length in TICKs (0 is played as 1)
//   NOTE_VALID  push request
//   NOTE_READY  FIFO not full
//   DOUT        nibble bus to the generator's DIN
//   LSEL/HSEL/HHSEL  load strobes for divider bits [3:0] / [7:4] / [10:8]
//   MUTE        gates the generator output
//   BUSY        FSM not idle
//   LEVEL       FIFO occupancy
//
// Build option: define TONE_SEQ_GAP_EN to insert a muted gap (until the next TICK)
// after every non-rest note. Undefined, consecutive notes play legato.
module tone_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DUR_W = 5
) (
  input  logic                         CLK,
  input  logic                         RST_C,
  input  logic                         TICK,
  input  logic                         ENABLE,
  input  logic [10:0]                  NOTE_DIV,
  input  logic [DUR_W-1:0]             NOTE_DUR,
  input  logic                         NOTE_VALID,
  output logic                         NOTE_READY,
  output logic [3:0]                   DOUT,
  output logic                         LSEL,
  output logic                         HSEL,
  output logic                         HHSEL,
  output logic                         MUTE,
  output logic                         BUSY,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

`ifdef TONE_SEQ_GAP_EN
  typedef enum logic [2:0] {StIdle, StLoadL, StLoadH, StLoadHh, StPlay, StGap} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoadL, StLoadH, StLoadHh, StPlay} state_e;
`endif

  // FIFO storage and pointers
  logic [10+DUR_W:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              ready_q;
  logic              push, pop;
  logic [10:0]       head_div;
  logic [DUR_W-1:0]  head_dur;

  // FSM and note registers
  state_e            state_q, state_d;
  logic [10:0]       div_q, div_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic              end_note;

  // Registered outputs
  logic [3:0]        dout_q, dout_d;
  logic              lsel_q, lsel_d, hsel_q, hsel_d, hhsel_q, hhsel_d;
  logic              mute_q, mute_d, busy_q, busy_d;

  assign {head_div, head_dur} = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push on the cycle its head is popped.
  assign push = NOTE_VALID && (ready_q || pop);

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    end_note = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ENABLE && (level_q != '0)) pop = 1'b1;
      end
      StLoadL:  state_d = StLoadH;
      StLoadH:  state_d = StLoadHh;
      StLoadHh: state_d = StPlay;
      StPlay: begin
        if (!ENABLE) begin
          state_d = StIdle;
        end else if (TICK) begin
          if (cnt_q == DUR_W'(1)) begin
`ifdef TONE_SEQ_GAP_EN
            if (div_q != '0) state_d = StGap;
            else             end_note = 1'b1;
`else
            end_note = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
      end
`ifdef TONE_SEQ_GAP_EN
      StGap: begin
        if (!ENABLE)   state_d = StIdle;
        else if (TICK) end_note = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    // End of note chains straight into the next queued entry when allowed.
    if (end_note) begin
      if (ENABLE && (level_q != '0)) pop = 1'b1;
      else                           state_d = StIdle;
    end

    if (pop) begin
      div_d   = head_div;
      cnt_d   = (head_dur == '0) ? DUR_W'(1) : head_dur;
      state_d = (head_div != '0) ? StLoadL : StPlay;
    end
  end

  // FIFO occupancy
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Output next values. Strobes lag the load state by one cycle; MUTE tracks
  // the state change directly so it rises on the edge that ends a note.
  always_comb begin
    dout_d  = 4'h0;
    lsel_d  = 1'b0;
    hsel_d  = 1'b0;
    hhsel_d = 1'b0;
    unique case (state_q)
      StLoadL: begin
        lsel_d = 1'b1;
        dout_d = div_q[3:0];
      end
      StLoadH: begin
        hsel_d = 1'b1;
        dout_d = div_q[7:4];
      end
      StLoadHh: begin
        hhsel_d = 1'b1;
        dout_d  = {1'b0, div_q[10:8]};
      end
      default: ;
    endcase

    busy_d = (state_d != StIdle);

    mute_d = mute_q;
`ifdef TONE_SEQ_GAP_EN
    if ((state_d == StIdle) || (state_d == StGap)) begin
`else
    if (state_d == StIdle) begin
`endif
      mute_d = 1'b1;
    end else if ((state_q == StPlay) && (state_d == StPlay) && !pop) begin
      // Sounding starts one cycle into PLAY; a rest keeps the output gated.
      mute_d = (div_q == '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      state_q  <= StIdle;
      div_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      dout_q   <= 4'h0;
      lsel_q   <= 1'b0;
      hsel_q   <= 1'b0;
      hhsel_q  <= 1'b0;
      mute_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q  <= level_d;
      ready_q  <= (level_d != LvlFull);
      dout_q   <= dout_d;
      lsel_q   <= lsel_d;
      hsel_q   <= hsel_d;
      hhsel_q  <= hhsel_d;
      mute_q   <= mute_d;
      busy_q   <= busy_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {NOTE_DIV, NOTE_DUR};
  end

  assign NOTE_READY = ready_q;
  assign DOUT       = dout_q;
  assign LSEL       = lsel_q;
  assign HSEL       = hsel_q;
  assign HHSEL      = hhsel_q;
  assign MUTE       = mute_q;
  assign BUSY       = busy_q;
  assign LEVEL      = level_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed bench for tone_sequencer (DEPTH=4, DUR_W=5).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_tone_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DUR_W = 5;
`ifdef TONE_SEQ_GAP_EN
  localparam logic GapEn = 1'b1;
`else
  localparam logic GapEn = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_C = 1'b0;
  logic             TICK = 1'b0;
  logic             ENABLE = 1'b0;
  logic [10:0]      NOTE_DIV = '0;
  logic [DUR_W-1:0] NOTE_DUR = '0;
  logic             NOTE_VALID = 1'b0;
  logic             NOTE_READY;
  logic [3:0]       DOUT;
  logic             LSEL, HSEL, HHSEL, MUTE, BUSY;
  logic [2:0]       LEVEL;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  tone_sequencer #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) dut (
    .CLK        (CLK),
    .RST_C      (RST_C),
    .TICK       (TICK),
    .ENABLE     (ENABLE),
    .NOTE_DIV   (NOTE_DIV),
    .NOTE_DUR   (NOTE_DUR),
    .NOTE_VALID (NOTE_VALID),
    .NOTE_READY (NOTE_READY),
    .DOUT       (DOUT),
    .LSEL       (LSEL),
    .HSEL       (HSEL),
    .HHSEL      (HHSEL),
    .MUTE       (MUTE),
    .BUSY       (BUSY),
    .LEVEL      (LEVEL)
  );

  typedef struct {
    logic        valid;
    logic [10:0] div;
    logic [4:0]  dur;
    logic        en;
    logic        tick;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [12:0] mk(input logic [3:0] dout, input logic l, input logic h,
                                     input logic hh, input logic mute, input logic busy,
                                     input logic [2:0] level, input logic ready);
    return {dout, l, h, hh, mute, busy, level, ready};
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_note(input logic [10:0] div, input logic [4:0] dur);
    NOTE_VALID = 1'b1;
    NOTE_DIV   = div;
    NOTE_DUR   = dur;
    step;
    NOTE_VALID = 1'b0;
  endtask

  task automatic do_reset;
    RST_C = 1'b0;
    #1;
    check("async_reset_level", int'(LEVEL), 0);
    check("async_reset_busy", int'(BUSY), 0);
    @(negedge CLK);
    RST_C = 1'b1;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got[$];

    // Reset with NOTE_VALID held
    NOTE_VALID = 1'b1;
    NOTE_DIV   = 11'h123;
    NOTE_DUR   = 5'd1;
    repeat (2) step;
    check("rst_level", int'(LEVEL), 0);
    check("rst_ready", int'(NOTE_READY), 1);
    check("rst_mute", int'(MUTE), 1);
    check("rst_busy", int'(BUSY), 0);
    check("rst_strobes", int'({LSEL, HSEL, HHSEL}), 0);
    check("rst_dout", int'(DOUT), 0);
    @(negedge CLK);
    RST_C = 1'b1;
    #1;
    check("rel_no_push_yet", int'(LEVEL), 0);
    step;
    check("rel_first_push", int'(LEVEL), 1);
    NOTE_VALID = 1'b0;
    do_reset;
    check("fifo_discarded", int'(LEVEL), 0);

    // Single note 0x5A3, 3 TICKs; TICKs during the load must be ignored
    vecs[0]  = '{1'b1, 11'h5A3, 5'd3, 1'b1, 1'b0, mk(4'h0, 0, 0, 0, 1, 0, 3'd1, 1)};
    vecs[1]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b0, mk(4'h0, 0, 0, 0, 1, 1, 3'd0, 1)};
    vecs[2]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b1, mk(4'h3, 1, 0, 0, 1, 1, 3'd0, 1)};
    vecs[3]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b1, mk(4'hA, 0, 1, 0, 1, 1, 3'd0, 1)};
    vecs[4]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b0, mk(4'h5, 0, 0, 1, 1, 1, 3'd0, 1)};
    vecs[5]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b0, mk(4'h0, 0, 0, 0, 0, 1, 3'd0, 1)};
    vecs[6]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b1, mk(4'h0, 0, 0, 0, 0, 1, 3'd0, 1)};
    vecs[7]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b0, mk(4'h0, 0, 0, 0, 0, 1, 3'd0, 1)};
    vecs[8]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b1, mk(4'h0, 0, 0, 0, 0, 1, 3'd0, 1)};
    vecs[9]  = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b1, mk(4'h0, 0, 0, 0, 1, GapEn, 3'd0, 1)};
    vecs[10] = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b0, mk(4'h0, 0, 0, 0, 1, GapEn, 3'd0, 1)};
    vecs[11] = '{1'b0, 11'h000, 5'd0, 1'b1, 1'b1, mk(4'h0, 0, 0, 0, 1, 0, 3'd0, 1)};
    for (int i = 0; i < 12; i++) begin
      NOTE_VALID = vecs[i].valid;
      NOTE_DIV   = vecs[i].div;
      NOTE_DUR   = vecs[i].dur;
      ENABLE     = vecs[i].en;
      TICK       = vecs[i].tick;
      step;
      check($sformatf("vec%0d", i),
            int'({DOUT, LSEL, HSEL, HHSEL, MUTE, BUSY, LEVEL, NOTE_READY}),
            int'(vecs[i].exp));
    end
    NOTE_VALID = 1'b0;
    TICK       = 1'b0;
    ENABLE     = 1'b0;
    step;

    // Fill the FIFO, hold off a fifth entry, then pop and push together
    for (int i = 0; i < 4; i++) begin
      push_note(11'((i + 1) * 17), 5'd1);
      check($sformatf("fill_level%0d", i), int'(LEVEL), i + 1);
      check($sformatf("fill_ready%0d", i), int'(NOTE_READY), (i < 3) ? 1 : 0);
    end
    NOTE_VALID = 1'b1;
    NOTE_DIV   = 11'h055;
    NOTE_DUR   = 5'd1;
    repeat (2) step;
    check("full_holdoff_level", int'(LEVEL), 4);
    check("full_holdoff_ready", int'(NOTE_READY), 0);
    ENABLE = 1'b1;
    TICK   = 1'b1;
    step;
    check("pop_push_level", int'(LEVEL), 4);
    NOTE_VALID = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step;
      if (LSEL) got.push_back(DOUT);
    end
    check("order_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) check($sformatf("order%0d", i), int'(got[i]), i + 1);
    check("drain_level", int'(LEVEL), 0);
    check("drain_busy", int'(BUSY), 0);
    check("drain_ready", int'(NOTE_READY), 1);
    ENABLE = 1'b0;
    TICK   = 1'b0;
    step;

    // Rest (2 TICKs) followed by 0x100 with a zero duration
    push_note(11'h000, 5'd2);
    push_note(11'h100, 5'd0);
    ENABLE = 1'b1;
    step;
    check("rest_busy", int'(BUSY), 1);
    check("rest_level", int'(LEVEL), 1);
    step;
    check("rest_mute_a", int'({MUTE, LSEL, HSEL, HHSEL}), 4'b1000);
    TICK = 1'b1;
    step;
    check("rest_mute_b", int'({MUTE, LSEL, HSEL, HHSEL}), 4'b1000);
    step;
    check("rest_end", int'({MUTE, LSEL, HSEL, HHSEL, LEVEL}), 7'b1000_000);
    TICK = 1'b0;
    step;
    check("n100_lsel", int'({LSEL, DOUT, MUTE}), 6'b1_0000_1);
    step;
    check("n100_hsel", int'({HSEL, DOUT}), 5'b1_0000);
    step;
    check("n100_hhsel", int'({HHSEL, DOUT, MUTE}), 6'b1_0001_1);
    step;
    check("n100_sound", int'(MUTE), 0);
    TICK = 1'b1;
    step;
    check("n100_end_mute", int'(MUTE), 1);
    step;
    check("n100_idle", int'(BUSY), 0);
    TICK   = 1'b0;
    ENABLE = 1'b0;
    step;

    // Abort mid-PLAY with two entries queued
    push_note(11'h0A1, 5'd4);
    push_note(11'h0B2, 5'd4);
    push_note(11'h0C3, 5'd4);
    ENABLE = 1'b1;
    step;
    check("abort_pop_level", int'(LEVEL), 2);
    step;
    check("abort_lsel", int'({LSEL, DOUT}), 5'b1_0001);
    repeat (3) step;
    check("abort_sounding", int'(MUTE), 0);
    ENABLE = 1'b0;
    step;
    check("abort_state", int'({MUTE, BUSY, LEVEL}), 5'b10_010);
    step;
    check("abort_kept", int'(LEVEL), 2);
    ENABLE = 1'b1;
    step;
    check("resume_level", int'(LEVEL), 1);
    step;
    check("resume_lsel", int'({LSEL, DOUT}), 5'b1_0010);
    ENABLE = 1'b0;
    step;
    check("dis_load_hsel", int'({HSEL, DOUT, BUSY}), 6'b1_1011_1);
    step;
    check("dis_load_hhsel", int'({HHSEL, BUSY}), 2'b11);
    step;
    check("dis_load_abort", int'({BUSY, MUTE, LEVEL}), 5'b01_001);
    do_reset;
    check("abort_reset_level", int'(LEVEL), 0);

    // Back-to-back notes: legato without the gap option, muted gap with it
    push_note(11'h0D1, 5'd1);
    push_note(11'h0E2, 5'd1);
    ENABLE = 1'b1;
    repeat (5) step;
    check("b2b_first_sound", int'(MUTE), 0);
    TICK = 1'b1;
    step;
`ifdef TONE_SEQ_GAP_EN
    check("gap_mute_a", int'({MUTE, BUSY}), 2'b11);
    TICK = 1'b0;
    step;
    check("gap_mute_b", int'(MUTE), 1);
    TICK = 1'b1;
    step;
    check("gap_leave", int'({MUTE, LEVEL}), 4'b1_000);
    TICK = 1'b0;
    step;
    check("gap_lsel", int'({LSEL, DOUT, MUTE}), 6'b1_0010_1);
    repeat (3) step;
    check("gap_second_sound", int'(MUTE), 0);
    TICK = 1'b1;
    step;
    check("gap_second_end", int'(MUTE), 1);
    step;
    check("gap_idle", int'(BUSY), 0);
`else
    check("legato_mute_a", int'({MUTE, LEVEL}), 4'b0_000);
    TICK = 1'b0;
    step;
    check("legato_lsel", int'({LSEL, DOUT, MUTE}), 6'b1_0010_0);
    for (int i = 0; i < 3; i++) begin
      step;
      check($sformatf("legato_mute%0d", i), int'(MUTE), 0);
    end
    TICK = 1'b1;
    step;
    check("legato_end", int'({MUTE, BUSY}), 2'b10);
`endif
    TICK   = 1'b0;
    ENABLE = 1'b0;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
